mem_store_unit: RTL and testbench
=================================

Name: mem_store_unit

Overview:
- Write-side counterpart of the instruction/load read path into the byte-wide Ram.
- The control FSM's WRITE_MEMORY state hands it one store (address, data, width).
- The unit serialises the store into little-endian byte writes over the 8-bit memory write port, then reports completion.
- One request is in flight at a time; the control FSM stalls on req_ready/done.

Parameters:
- ADDR_W, 32, width of the byte address and of mem_addr_bus.
- MAX_BYTES, 4, largest store in bytes; sizes byte_idx.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  store request present
- req_ready  out  1  unit idle and able to accept
- req_addr  in  ADDR_W  byte address of the lowest byte
- req_data  in  32  store data, LSB-aligned
- req_width  in  2  funct3 width encoding: 0 = byte, 1 = half, 2 = word, 3 = reserved
- done  out  1  one-cycle pulse: store fully written
- store_err  out  1  one-cycle pulse: request rejected, no byte written
- mem_addr_bus  out  ADDR_W  byte address to Ram
- bus_to_mem  out  8  byte to Ram
- write_enable  out  1  Ram byte write strobe

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state = IDLE, req_ready = 1, done = 0, store_err = 0, write_enable = 0, mem_addr_bus = 0, bus_to_mem = 0.
- All outputs are registered.
- States: IDLE, WRITE_BYTE, FINISH, ERROR.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, capture addr, data and width, and set byte_idx = 0.
  - Valid width goes to WRITE_BYTE. Reserved width (3) goes to ERROR.
- WRITE_BYTE:
  - req_ready = 0, write_enable = 1.
  - mem_addr_bus = captured addr + byte_idx, modulo 2^ADDR_W.
  - bus_to_mem = data[8*byte_idx +: 8].
  - byte_idx increments each cycle.
  - After byte n-1 (n = 1/2/4), go to FINISH.
- FINISH: done = 1 for exactly one cycle, write_enable = 0, then IDLE.
- ERROR: store_err = 1 for exactly one cycle, no write, then IDLE.
- Latency:
  - Accept edge = cycle 0; bytes on cycles 1..n; done on cycle n+1.
  - req_ready is back to 1 on cycle n+2.
  - Word store: 6 cycles accept-to-ready.
- Upper data bits beyond the width are ignored: a byte store of 0xAABBCCDD writes only 0xDD.
- req_valid while not ready is ignored. The requester holds it; no request is lost or double-accepted.
- Inputs are sampled only at accept; later changes of req_* have no effect on the store in progress.
- Address wrap: a word at 0xFFFF_FFFE writes 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000, 0x0000_0001.
- Reset mid-store:
  - Abort on that edge; write_enable = 0 from the next cycle.
  - No done is issued; bytes already written stay written.
- rst and req_valid in the same cycle: reset wins, request not accepted.

Optional Feature:
- Macro: STORE_ALIGN_CHECK_EN.
- Defined:
  - A half at an odd address, or a word with addr[1:0] != 0, goes IDLE -> ERROR.
  - store_err pulses once, zero bytes are written.
- Undefined:
  - No alignment check; misaligned stores are written byte-serially like aligned ones.
  - store_err fires only for the reserved width.

Decomposition:
- Shared package ctrl_pkg:
  - StoreWidth enum (BITS8 = 0, BITS16 = 1, BITS32 = 2), shared with the load decode funct3 width.
  - StoreState enum.
  - Constant BYTES_PER_WORD = 4.
- Sub-module store_byte_sel: combinational width-to-byte-count and data byte-lane selection, reused later by the load path for sign/zero extension.

Test Plan:
- Word store, addr 0x80, data 0x1122_3344 -> write_enable high cycles 1–4; mem[0x80..0x83] = 44, 33, 22, 11; done pulses cycle 5; req_ready = 1 cycle 6.
- Byte store, addr 0x11, data 0xAABB_CCDD -> single write of 0xDD at 0x11; done on cycle 2; 0x12 untouched.
- Width 3 -> store_err pulses once, write_enable never asserted, done never asserted.
- Word at 0x6 under STORE_ALIGN_CHECK_EN -> store_err, memory unchanged. Same request without the macro -> 4 bytes at 0x6..0x9 and done.
- Word at 0xFFFF_FFFE -> address sequence FFFF_FFFE, FFFF_FFFF, 0, 1.
- rst asserted on cycle 2 of a word store -> cycle 3 write_enable = 0, req_ready = 1, no done; the next request completes normally.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control-path types: store/load width encoding, store FSM states and
// word geometry used by the memory store and load units.
package ctrl_pkg;

    localparam int BYTES_PER_WORD = 4;

    // funct3 width field; the load decode uses the same encoding
    typedef enum logic [1:0] {
        BITS8  = 2'd0,
        BITS16 = 2'd1,
        BITS32 = 2'd2
    } StoreWidth;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BYTE = 2'd1,
        FINISH     = 2'd2,
        ERROR      = 2'd3
    } StoreState;

    // Number of bytes moved for a width code; 0 marks the reserved encoding.
    function automatic logic [2:0] store_bytes(input logic [1:0] width);
        logic [2:0] n;
        case (width)
            BITS8:   n = 3'd1;
            BITS16:  n = 3'd2;
            BITS32:  n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/store_byte_sel.sv
// Combinational width-to-byte-count decode and byte-lane selection; shared
// with the load path, which needs the same lane split for sign/zero extension.
module store_byte_sel
    import ctrl_pkg::*;
#(
    parameter int MAX_BYTES = BYTES_PER_WORD,
    localparam int LANE_W = $clog2(MAX_BYTES)
) (
    input  logic [1:0]             width,
    input  logic [8*MAX_BYTES-1:0] data,
    input  logic [LANE_W-1:0]      lane,
    output logic [LANE_W:0]        byte_count,
    output logic [7:0]             lane_byte
);

    logic [7:0] lanes [MAX_BYTES];

    genvar gi;
    generate
        for (gi = 0; gi < MAX_BYTES; gi++) begin : g_lane
            assign lanes[gi] = data[8*gi +: 8];
        end
    endgenerate

    assign lane_byte  = lanes[lane];
    assign byte_count = (LANE_W + 1)'(store_bytes(width));

endmodule

// File: rtl/mem_store_unit.sv
// Serialises one store into little-endian byte writes on the 8-bit Ram port.
// Optional build macro STORE_ALIGN_CHECK_EN rejects misaligned half/word stores.
module mem_store_unit
    import ctrl_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MAX_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_width,
    output logic              done,
    output logic              store_err,
    output logic [ADDR_W-1:0] mem_addr_bus,
    output logic [7:0]        bus_to_mem,
    output logic              write_enable
);

    localparam int IDX_W = $clog2(MAX_BYTES);
    localparam int CNT_W = IDX_W + 1;

    StoreState         state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       data_reg, data_next;
    logic [1:0]        width_reg, width_next;
    logic [IDX_W-1:0]  byte_idx_reg, byte_idx_next;

    logic              req_ready_reg, req_ready_next;
    logic              done_reg, done_next;
    logic              store_err_reg, store_err_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [7:0]        bus_reg, bus_next;

    logic [IDX_W-1:0]  lane_sel;
    logic [CNT_W-1:0]  byte_count;
    logic [7:0]        lane_byte;
    logic              last_byte;
    logic              misaligned;

    // Outputs are registered, so the lane looked up is the one presented next cycle.
    assign lane_sel  = byte_idx_reg + IDX_W'(1);
    assign last_byte = (CNT_W'(byte_idx_reg) + CNT_W'(1)) == byte_count;

    store_byte_sel #(
        .MAX_BYTES (MAX_BYTES)
    ) u_byte_sel (
        .width      (width_reg),
        .data       (data_reg),
        .lane       (lane_sel),
        .byte_count (byte_count),
        .lane_byte  (lane_byte)
    );

`ifdef STORE_ALIGN_CHECK_EN
    assign misaligned = ((req_width == BITS16) && req_addr[0]) ||
                        ((req_width == BITS32) && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        data_next      = data_reg;
        width_next     = width_reg;
        byte_idx_next  = byte_idx_reg;
        req_ready_next = 1'b0;
        done_next      = 1'b0;
        store_err_next = 1'b0;
        we_next        = 1'b0;
        mem_addr_next  = mem_addr_reg;
        bus_next       = bus_reg;

        case (state_reg)
            IDLE: begin
                req_ready_next = 1'b1;
                if (req_valid && req_ready_reg) begin
                    addr_next      = req_addr;
                    data_next      = req_data;
                    width_next     = req_width;
                    byte_idx_next  = '0;
                    req_ready_next = 1'b0;
                    if ((req_width == 2'd3) || misaligned) begin
                        state_next     = ERROR;
                        store_err_next = 1'b1;
                    end else begin
                        // Byte 0 goes straight onto the bus on the cycle after accept.
                        state_next    = WRITE_BYTE;
                        we_next       = 1'b1;
                        mem_addr_next = req_addr;
                        bus_next      = req_data[7:0];
                    end
                end
            end
            WRITE_BYTE: begin
                if (last_byte) begin
                    state_next = FINISH;
                    done_next  = 1'b1;
                end else begin
                    byte_idx_next = lane_sel;
                    we_next       = 1'b1;
                    mem_addr_next = addr_reg + ADDR_W'(lane_sel);
                    bus_next      = lane_byte;
                end
            end
            FINISH: begin
                state_next     = IDLE;
                req_ready_next = 1'b1;
            end
            ERROR: begin
                state_next     = IDLE;
                req_ready_next = 1'b1;
            end
            default: begin
                state_next     = IDLE;
                req_ready_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            data_reg      <= '0;
            width_reg     <= '0;
            byte_idx_reg  <= '0;
            req_ready_reg <= 1'b1;
            done_reg      <= 1'b0;
            store_err_reg <= 1'b0;
            we_reg        <= 1'b0;
            mem_addr_reg  <= '0;
            bus_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            data_reg      <= data_next;
            width_reg     <= width_next;
            byte_idx_reg  <= byte_idx_next;
            req_ready_reg <= req_ready_next;
            done_reg      <= done_next;
            store_err_reg <= store_err_next;
            we_reg        <= we_next;
            mem_addr_reg  <= mem_addr_next;
            bus_reg       <= bus_next;
        end
    end

    assign req_ready    = req_ready_reg;
    assign done         = done_reg;
    assign store_err    = store_err_reg;
    assign write_enable = we_reg;
    assign mem_addr_bus = mem_addr_reg;
    assign bus_to_mem   = bus_reg;

endmodule

// File: tb/tb_mem_store_unit.sv
// Bench for mem_store_unit: directed vector table, hand-written reset corner
// cases and randomized stores checked cycle by cycle against a store model.
module tb_mem_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_width;
    logic        done;
    logic        store_err;
    logic [31:0] mem_addr_bus;
    logic [7:0]  bus_to_mem;
    logic        write_enable;

    int checks   = 0;
    int failures = 0;

    logic [7:0] dut_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  width;
        int          exp_n;
        bit          exp_err;
    } vec_t;

    vec_t vecs [6];

    mem_store_unit #(.ADDR_W(32), .MAX_BYTES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_width    (req_width),
        .done         (done),
        .store_err    (store_err),
        .mem_addr_bus (mem_addr_bus),
        .bus_to_mem   (bus_to_mem),
        .write_enable (write_enable)
    );

    always #5 clk = ~clk;

    // Byte-wide Ram as seen by the unit
    always @(posedge clk) begin
        if (write_enable) dut_mem[mem_addr_bus] = bus_to_mem;
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endfunction

    // Reference rules: byte count from width, reserved width (and optionally misalignment) rejected.
    function automatic void model(input logic [31:0] a, input logic [1:0] w,
                                  output int n, output bit err);
        err = (w == 2'd3);
`ifdef STORE_ALIGN_CHECK_EN
        if (w == 2'd1 && a[0]) err = 1'b1;
        if (w == 2'd2 && a[1:0] != 2'b00) err = 1'b1;
`endif
        n = err ? 0 : (1 << w);
    endfunction

    task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w,
                             input int exp_n, input bit exp_err);
        int waited = 0;
        int last;
        int fails_before = failures;
        while (1) begin
            @(negedge clk);
            if (req_ready) break;
            waited++;
            if (waited > 20) begin
                chk("ready_timeout", {31'b0, req_ready}, 32'd1);
                return;
            end
        end
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_width = w;
        @(posedge clk);
        last = exp_err ? 2 : exp_n + 2;
        for (int c = 1; c <= last; c++) begin
            bit exp_we;
            @(negedge clk);
            exp_we = !exp_err && (c <= exp_n);
            chk("write_enable", {31'b0, write_enable}, {31'b0, exp_we});
            chk("done", {31'b0, done}, {31'b0, (!exp_err && c == exp_n + 1)});
            chk("store_err", {31'b0, store_err}, {31'b0, (exp_err && c == 1)});
            chk("req_ready", {31'b0, req_ready}, {31'b0, (c == last)});
            if (exp_we) begin
                chk("mem_addr_bus", mem_addr_bus, a + 32'(c - 1));
                chk("bus_to_mem", {24'b0, bus_to_mem}, (d >> (8 * (c - 1))) & 32'hFF);
            end
            // Hold a different request while busy; it must be ignored.
            if (c < last) begin
                req_valid = 1'b1;
                req_addr  = $urandom;
                req_data  = $urandom;
                req_width = 2'($urandom_range(0, 3));
            end else begin
                req_valid = 1'b0;
            end
        end
        for (int k = 0; k < exp_n; k++) ref_mem[a + 32'(k)] = 8'((d >> (8 * k)) & 32'hFF);
        $display("store addr=%08h data=%08h width=%0d bytes=%0d err=%0d : %s",
                 a, d, w, exp_n, exp_err, (failures == fails_before) ? "ok" : "bad");
    endtask

    task automatic mem_compare(input string tag);
        chk({tag, "_mem_size"}, 32'(dut_mem.num()), 32'(ref_mem.num()));
        foreach (ref_mem[k]) begin
            chk({tag, "_mem_present"}, {31'b0, dut_mem.exists(k) == 1}, 32'd1);
            if (dut_mem.exists(k)) chk({tag, "_mem_byte"}, {24'b0, dut_mem[k]}, {24'b0, ref_mem[k]});
        end
    endtask

    initial begin
        int n;
        bit err;
        logic [31:0] a, d;
        logic [1:0] w;

        vecs[0] = '{32'h0000_0080, 32'h1122_3344, 2'd2, 4, 1'b0};
        vecs[1] = '{32'h0000_0011, 32'hAABB_CCDD, 2'd0, 1, 1'b0};
        vecs[2] = '{32'h0000_0040, 32'h1234_5678, 2'd3, 0, 1'b1};
`ifdef STORE_ALIGN_CHECK_EN
        vecs[3] = '{32'h0000_0006, 32'h5566_7788, 2'd2, 0, 1'b1};
        vecs[5] = '{32'h0000_0021, 32'h0000_BEEF, 2'd1, 0, 1'b1};
`else
        vecs[3] = '{32'h0000_0006, 32'h5566_7788, 2'd2, 4, 1'b0};
        vecs[5] = '{32'h0000_0021, 32'h0000_BEEF, 2'd1, 2, 1'b0};
`endif
        vecs[4] = '{32'hFFFF_FFFE, 32'h0102_0304, 2'd2, 4, 1'b0};

        rst = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        req_data = '0;
        req_width = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_store_err", {31'b0, store_err}, 32'd0);
        chk("rst_write_enable", {31'b0, write_enable}, 32'd0);
        chk("rst_mem_addr_bus", mem_addr_bus, 32'd0);
        chk("rst_bus_to_mem", {24'b0, bus_to_mem}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run_store(vecs[i].addr, vecs[i].data, vecs[i].width, vecs[i].exp_n, vecs[i].exp_err);

        chk("word_0x83", {24'b0, dut_mem.exists(32'h83) ? dut_mem[32'h83] : 8'h00}, 32'h11);
        chk("byte_0x11", {24'b0, dut_mem.exists(32'h11) ? dut_mem[32'h11] : 8'h00}, 32'hDD);
        chk("untouched_0x12", {31'b0, dut_mem.exists(32'h12) == 1}, 32'd0);
        chk("reserved_no_write", {31'b0, dut_mem.exists(32'h40) == 1}, 32'd0);
        chk("wrap_0x1", {24'b0, dut_mem.exists(32'h1) ? dut_mem[32'h1] : 8'h00}, 32'h01);
        mem_compare("table");

        // Reset on cycle 2 of a word store
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h0000_0200;
        req_data  = 32'hCAFE_BABE;
        req_width = 2'd2;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("midrst_c1_we", {31'b0, write_enable}, 32'd1);
        chk("midrst_c1_addr", mem_addr_bus, 32'h200);
        @(negedge clk);
        chk("midrst_c2_byte", {24'b0, bus_to_mem}, 32'hBA);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_c3_we", {31'b0, write_enable}, 32'd0);
        chk("midrst_c3_ready", {31'b0, req_ready}, 32'd1);
        chk("midrst_c3_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        chk("midrst_c4_done", {31'b0, done}, 32'd0);
        chk("midrst_c4_we", {31'b0, write_enable}, 32'd0);
        ref_mem[32'h200] = 8'hBE;
        ref_mem[32'h201] = 8'hBA;
        $display("store addr=00000200 data=cafebabe width=2 aborted by reset after 2 bytes");
        run_store(32'h0000_0204, 32'hDEAD_BEEF, 2'd2, 4, 1'b0);

        // Reset and request in the same cycle: reset wins
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0000_0300;
        req_data  = 32'h7777_7777;
        req_width = 2'd2;
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        chk("rstreq_c1_ready", {31'b0, req_ready}, 32'd1);
        chk("rstreq_c1_we", {31'b0, write_enable}, 32'd0);
        @(negedge clk);
        chk("rstreq_c2_we", {31'b0, write_enable}, 32'd0);
        chk("rstreq_c2_done", {31'b0, done}, 32'd0);
        $display("store addr=00000300 width=2 with reset in same cycle: not accepted");
        mem_compare("reset");

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if (i % 5 == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            d = $urandom;
            w = 2'($urandom_range(0, 3));
            model(a, w, n, err);
            run_store(a, d, w, n, err);
        end
        mem_compare("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "timeout");
    end

endmodule
